// File: rtl/mipi_packet_scheduler.sv
// Round-robin arbiter that hands one requester's payload to the MIPI packet
// generator per video frame, strobing it at the frame boundary and acking on completion.
module mipi_packet_scheduler #(
    parameter int          NREQ          = 4,
    parameter int          DLEN          = 43,
    parameter logic [9:0]  X_LAST        = 10'd799,
    parameter logic [9:0]  Y_LAST        = 10'd524,
    parameter logic [15:0] PKT_COUNT_RST = 16'h0000
) (
    input  logic                     tx_pixel_clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DLEN*8-1:0]   req_data,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic                     gen_busy,
    output logic [DLEN*8-1:0]        gen_data,
    output logic                     gen_data_available,
    output logic [NREQ-1:0]          ack,
    output logic [2:0]               grant_id,
    output logic                     sched_busy,
    output logic                     err_nostart,
    output logic [15:0]              pkt_count
);

    localparam int PW = DLEN * 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_SEND, S_DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_data;
    logic            r_gda;
    logic [NREQ-1:0] r_ack;
    logic [2:0]      r_grant;
    logic [2:0]      r_last;
    logic            r_busy;
    logic            r_err;
    logic            r_seen;
    logic [15:0]     r_pkt;

    logic            w_frameEnd;
    logic            w_complete;
    logic            w_found;
    logic [2:0]      w_winner;
    int              w_cand;

    assign w_frameEnd = (x == X_LAST) && (y == Y_LAST);
    assign w_complete = (r_seen && !gen_busy) || (w_frameEnd && (r_seen || gen_busy));

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(r_last) + k) % NREQ;
            if (!w_found && |(req & (NREQ'(1) << w_cand))) begin
                w_found  = 1'b1;
                w_winner = 3'(w_cand);
            end
        end
    end

    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_gda   <= 1'b0;
            r_ack   <= '0;
            r_grant <= '0;
            r_last  <= 3'(NREQ - 1);
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_seen  <= 1'b0;
            r_pkt   <= PKT_COUNT_RST;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_data  <= req_data[int'(w_winner)*PW +: PW];
                        r_grant <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    if (w_frameEnd) begin
                        r_gda   <= 1'b1;
                        r_seen  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (gen_busy)
                        r_seen <= 1'b1;
                    // Completion wins over the no-start error when both hit at frame end.
                    if (w_complete) begin
                        r_gda   <= 1'b0;
                        r_ack   <= NREQ'(1) << r_grant;
                        r_last  <= r_grant;
                        r_pkt   <= r_pkt + 16'd1;
                        r_state <= S_DONE;
                    end else if (w_frameEnd) begin
                        r_gda   <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gen_data           = r_data;
    assign gen_data_available = r_gda;
    assign ack                = r_ack;
    assign grant_id           = r_grant;
    assign sched_busy         = r_busy;
    assign err_nostart        = r_err;
    assign pkt_count          = r_pkt;

endmodule

// File: tb/tb_mipi_packet_scheduler.sv
// Directed bench for mipi_packet_scheduler: stimulus queues expected ack/error
// events, a negedge monitor pops and compares them whenever the DUT reports one.
module tb_mipi_packet_scheduler;

    localparam int NREQ = 4;
    localparam int DLEN = 43;
    localparam int PW   = DLEN * 8;
    localparam logic [9:0] X_LAST = 10'd799;
    localparam logic [9:0] Y_LAST = 10'd524;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*PW-1:0]     reqData;
    logic [9:0]             x;
    logic [9:0]             y;
    logic                   genBusy;
    logic [PW-1:0]          genData;
    logic                   genDataAvailable;
    logic [NREQ-1:0]        ack;
    logic [2:0]             grantId;
    logic                   schedBusy;
    logic                   errNostart;
    logic [15:0]            pktCount;

    logic [PW-1:0]          wrapGenData;
    logic                   wrapGda;
    logic [NREQ-1:0]        wrapAck;
    logic [2:0]             wrapGrantId;
    logic                   wrapSchedBusy;
    logic                   wrapErr;
    logic [15:0]            wrapPktCount;

    typedef struct {
        logic            isErr;
        logic [NREQ-1:0] ack;
        logic [2:0]      grant;
        logic [PW-1:0]   data;
        logic [15:0]     pkt;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   expPkt  = 0;

    mipi_packet_scheduler #(.NREQ(NREQ), .DLEN(DLEN), .X_LAST(X_LAST), .Y_LAST(Y_LAST)) dut (
        .tx_pixel_clk(clk), .rst_n(rst_n), .req(req), .req_data(reqData),
        .x(x), .y(y), .gen_busy(genBusy), .gen_data(genData),
        .gen_data_available(genDataAvailable), .ack(ack), .grant_id(grantId),
        .sched_busy(schedBusy), .err_nostart(errNostart), .pkt_count(pktCount)
    );

    // Second copy with the packet counter preloaded just below its wrap point.
    mipi_packet_scheduler #(.NREQ(NREQ), .DLEN(DLEN), .X_LAST(X_LAST), .Y_LAST(Y_LAST),
                            .PKT_COUNT_RST(16'hFFFF)) uWrap (
        .tx_pixel_clk(clk), .rst_n(rst_n), .req(req), .req_data(reqData),
        .x(x), .y(y), .gen_busy(genBusy), .gen_data(wrapGenData),
        .gen_data_available(wrapGda), .ack(wrapAck), .grant_id(wrapGrantId),
        .sched_busy(wrapSchedBusy), .err_nostart(wrapErr), .pkt_count(wrapPktCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pay(input int i);
        logic [PW-1:0] p;
        for (int b = 0; b < DLEN; b++)
            p[b*8 +: 8] = 8'((i + 1) * 17);
        return p;
    endfunction

    task automatic setPayloads();
        for (int i = 0; i < NREQ; i++)
            reqData[i*PW +: PW] = pay(i);
    endtask

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pushExp(input logic isErr, input int src, input int pkt);
        exp_t e;
        e.isErr = isErr;
        e.ack   = isErr ? '0 : NREQ'(1) << src;
        e.grant = 3'(src);
        e.data  = pay(src);
        e.pkt   = 16'(pkt);
        sbQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the scheduler to sit in WAIT_SOF holding a fresh grant.
    task automatic waitGrant(input int src);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            if (schedBusy && !genDataAvailable && ack == '0)
                ok = 1'b1;
        end
        checkOutput("grantReached", PW'(ok), PW'(1));
        checkOutput("grantId", PW'(grantId), PW'(src));
    endtask

    task automatic frameEnd();
        x = X_LAST;
        y = Y_LAST;
        tick();
        x = '0;
        y = '0;
    endtask

    task automatic applyStimulus(input int src, input int busyLen, input bit simult, input bit corrupt);
        waitGrant(src);
        expPkt++;
        pushExp(1'b0, src, expPkt);
        frameEnd();
        checkOutput("strobeRise", PW'(genDataAvailable), PW'(1));
        repeat (3) tick();
        genBusy = 1'b1;
        if (corrupt)
            reqData[src*PW +: PW] = '1;
        repeat (busyLen) tick();
        genBusy = 1'b0;
        if (simult) begin
            x = X_LAST;
            y = Y_LAST;
        end
        tick();
        x = '0;
        y = '0;
        checkOutput("ackTiming", PW'(ack), PW'(NREQ'(1) << src));
        checkOutput("strobeFall", PW'(genDataAvailable), PW'(0));
        @(negedge clk);
        #1;
        setPayloads();
    endtask

    always @(negedge clk) begin
        if (rst_n && (ack != '0 || errNostart)) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpectedEvent: got ack=%0h err=%0b expected no event", ack, errNostart);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sbErr", PW'(errNostart), PW'(e.isErr));
                checkOutput("sbAck", PW'(ack), PW'(e.ack));
                checkOutput("sbGrant", PW'(grantId), PW'(e.grant));
                checkOutput("sbData", genData, e.data);
                checkOutput("sbPktCount", PW'(pktCount), PW'(e.pkt));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        x       = '0;
        y       = '0;
        genBusy = 1'b0;
        setPayloads();
        repeat (3) tick();
        checkOutput("rstStrobe", PW'(genDataAvailable), PW'(0));
        checkOutput("rstAck", PW'(ack), PW'(0));
        checkOutput("rstGrant", PW'(grantId), PW'(0));
        checkOutput("rstBusy", PW'(schedBusy), PW'(0));
        checkOutput("rstErr", PW'(errNostart), PW'(0));
        checkOutput("rstPkt", PW'(pktCount), PW'(0));
        checkOutput("rstData", genData, '0);
        rst_n = 1'b1;

        // Round robin with all sources requesting, one corrupted payload, one simultaneous exit.
        req = 4'b1111;
        applyStimulus(0, 5, 1'b0, 1'b0);
        applyStimulus(1, 4, 1'b0, 1'b0);
        applyStimulus(2, 6, 1'b0, 1'b1);
        applyStimulus(3, 3, 1'b1, 1'b0);
        applyStimulus(0, 5, 1'b0, 1'b0);
        req = 4'b0100;
        applyStimulus(2, 10, 1'b0, 1'b0);
        req = '0;
        checkOutput("pktAfterSix", PW'(pktCount), PW'(6));

        // Generator never starts: error at the next frame end, then retry of the same source.
        repeat (3) tick();
        req = 4'b0010;
        waitGrant(1);
        pushExp(1'b1, 1, expPkt);
        frameEnd();
        checkOutput("noStartStrobe", PW'(genDataAvailable), PW'(1));
        repeat (5) tick();
        frameEnd();
        checkOutput("errPulse", PW'(errNostart), PW'(1));
        checkOutput("errStrobeDrop", PW'(genDataAvailable), PW'(0));
        applyStimulus(1, 4, 1'b0, 1'b0);
        req = '0;

        // Asynchronous reset in the middle of a packet.
        repeat (3) tick();
        req = 4'b1000;
        waitGrant(3);
        frameEnd();
        genBusy = 1'b1;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncStrobe", PW'(genDataAvailable), PW'(0));
        checkOutput("asyncBusy", PW'(schedBusy), PW'(0));
        checkOutput("asyncPkt", PW'(pktCount), PW'(0));
        checkOutput("wrapPreload", PW'(wrapPktCount), PW'(16'hFFFF));
        genBusy = 1'b0;
        req = 4'b0110;
        tick();
        rst_n = 1'b1;
        expPkt = 0;
        applyStimulus(1, 4, 1'b0, 1'b0);
        req = '0;
        checkOutput("pktWrap", PW'(wrapPktCount), PW'(0));

        repeat (4) tick();
        checkOutput("sbDrained", PW'(sbQ.size()), PW'(0));
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mipi_packet_scheduler.md
# mipi_packet_scheduler

Arbitrates up to NREQ payload sources (miner result/nonce producers) for the single MIPI pixel packet generator and sequences that generator one packet per video frame. Round-robin selects a pending requester, latches its payload, raises the generator's data-available strobe exactly at the frame boundary, and holds payload and strobe stable until the packet completes. On completion it returns a one-cycle acknowledge to the winning requester. Sits between the miner result logic and the packet generator in the tx_pixel_clk domain.

## Interface
- NREQ, 4: number of requesters (2..8).
- DLEN, 43: payload length in bytes; must match the generator's DLEN.
- X_LAST, 10'd799: last pixel column of the frame timing.
- Y_LAST, 10'd524: last line of the frame timing.

- tx_pixel_clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per source; held until ack.
- req_data  in  NREQ*DLEN*8  payloads; source i occupies bits [i*DLEN*8 +: DLEN*8].
- x, y  in  10 each  current pixel column/line from the timing generator.
- gen_busy  in  1  busy from the packet generator.
- gen_data  out  DLEN*8  latched payload to the generator.
- gen_data_available  out  1  packet strobe to the generator.
- ack  out  NREQ  one-cycle completion pulse, one-hot.
- grant_id  out  3  index of the current/last grant.
- sched_busy  out  1  high in every state except IDLE.
- err_nostart  out  1  one-cycle pulse: frame ended without gen_busy ever rising.
- pkt_count  out  16  completed packets; wraps 16'hFFFF -> 0.

## Operation
- Reset (async, rst_n=0): state IDLE; gen_data, gen_data_available, ack, grant_id, sched_busy, err_nostart, pkt_count all 0; round-robin pointer last=NREQ-1 (source 0 has priority first); seen_busy=0.
- States IDLE, WAIT_SOF, SEND, DONE.
- IDLE: if req != 0, select the first set bit searching from (last+1) mod NREQ upward with wrap; latch gen_data <= payload of the winner; grant_id <= winner; go WAIT_SOF. Otherwise stay.
- WAIT_SOF: when sampled x==X_LAST && y==Y_LAST, set gen_data_available=1 and clear seen_busy; go SEND. The strobe is therefore high from pixel (0,0) of the next frame, so the generator captures SOF and header.
- SEND: strobe and gen_data held constant. seen_busy <= 1 on any sampled gen_busy=1. Exit conditions:
  - seen_busy=1 && gen_busy=0: completion -> DONE.
  - x==X_LAST && y==Y_LAST: if seen_busy=1 or gen_busy=1, completion -> DONE; else err_nostart pulse, strobe dropped, pointer unchanged, return to IDLE (request retried by normal arbitration).
  - Both true in the same cycle: completion.
- DONE (1 cycle): ack[grant_id]=1, gen_data_available=0, last <= grant_id, pkt_count += 1; go IDLE.
- req_data changes after grant are ignored; req dropped after grant does not abort the packet (ack still issued).
- A requester still asserting req in the cycle after ack is treated as a new request.
- Requesters must not assert req_data changes relying on ack timing; payload capture happens only in IDLE.

## Timing
- req rising in IDLE at edge t -> grant_id/gen_data/sched_busy valid after edge t.
- gen_data_available rises on the edge sampling (X_LAST, Y_LAST); stays high through at least one full frame minus completion.
- ack asserted exactly one cycle, the cycle after the completion edge; gen_data_available falls on that same edge.
- Minimum packet-to-packet spacing: one frame (one packet per frame maximum).
- err_nostart and ack are mutually exclusive, each one cycle wide.
- Reset mid-SEND drops the strobe immediately (async); no ack is produced for the aborted packet.

## Test plan
- Single request: req=4'b0100, payload 0x11..., gen_busy high 3..20 cycles after frame start -> strobe rises at (799,524), ack=4'b0100 one cycle after gen_busy falls, pkt_count=1.
- Round-robin: req=4'b1111 held, each re-raised after ack -> grant order 0,1,2,3,0; one packet per frame.
- No-start: gen_busy tied 0 -> err_nostart pulse at the next (799,524), no ack, same source regranted, pkt_count unchanged.
- Payload stability: change req_data of the granted source during SEND -> gen_data unchanged until DONE.
- Simultaneous exit: gen_busy falls on the edge sampling (799,524) -> single ack, no err_nostart.
- Async reset in SEND -> all outputs 0 immediately; next grant goes to lowest pending index; pkt_count wraps from 16'hFFFF to 0 on preloaded test.
